// File: rtl/pc_ir_unit.sv
// Program counter / instruction register unit: holds PC, PC+4, IR, a retired
// instruction counter and a sticky misaligned-jr flag; computes next PC for
// sequential, beq, j/jal and jr flows and decodes the instruction fields.
module pc_ir_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        pcwr,
  input  logic        irwr,
  input  logic [1:0]  npc_sel,
  input  logic        zero,
  input  logic [31:0] rs_data,
  input  logic [31:0] imem_rdata,
  output logic [31:0] imem_addr,
  output logic [31:0] pc,
  output logic [31:0] link_addr,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [15:0] imm16,
  output logic [31:0] retired,
  output logic        addr_err
);

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_3000;
  localparam logic [XLEN-1:0] RESET_PC4 = 32'h0000_3004;
  localparam logic [XLEN-1:0] INSTR_BYTES = 32'd4;

  localparam logic [1:0] SEL_SEQ = 2'b00;
  localparam logic [1:0] SEL_BEQ = 2'b01;
  localparam logic [1:0] SEL_J   = 2'b10;
  localparam logic [1:0] SEL_JR  = 2'b11;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc4_q, pc4_d;
  logic [XLEN-1:0] ir_q, ir_d;
  logic [XLEN-1:0] retired_q, retired_d;
  logic            addr_err_q, addr_err_d;

  logic [XLEN-1:0] npc;
  logic [XLEN-1:0] br_off;
  logic            jr_misaligned;

  // Next-PC selection from the pre-edge register values
  always_comb begin
    br_off        = {{14{ir_q[15]}}, ir_q[15:0], 2'b00};
    npc           = pc_q + INSTR_BYTES;
    jr_misaligned = 1'b0;
    case (npc_sel)
      SEL_SEQ: npc = pc_q + INSTR_BYTES;
      SEL_BEQ: npc = zero ? (pc4_q + br_off) : pc4_q;
      SEL_J:   npc = {pc4_q[31:28], ir_q[25:0], 2'b00};
      SEL_JR: begin
        npc           = {rs_data[31:2], 2'b00};
        jr_misaligned = (rs_data[1:0] != 2'b00);
      end
      default: npc = pc_q + INSTR_BYTES;
    endcase
  end

  // Register next-state: hold unless the matching write enable is set
  always_comb begin
    pc_d       = pc_q;
    pc4_d      = pc4_q;
    ir_d       = ir_q;
    retired_d  = retired_q;
    addr_err_d = addr_err_q;
    if (irwr) begin
      ir_d      = imem_rdata;
      pc4_d     = pc_q + INSTR_BYTES;
      retired_d = retired_q + 32'd1;
    end
    if (pcwr) begin
      pc_d = npc;
      if (jr_misaligned) begin
        addr_err_d = 1'b1;
      end
    end
  end

  // State registers with synchronous active-low reset taking priority
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q       <= RESET_PC;
      pc4_q      <= RESET_PC4;
      ir_q       <= '0;
      retired_q  <= '0;
      addr_err_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      pc4_q      <= pc4_d;
      ir_q       <= ir_d;
      retired_q  <= retired_d;
      addr_err_q <= addr_err_d;
    end
  end

  // Outputs and instruction field decode straight from the registers
  always_comb begin
    imem_addr = pc_q;
    pc        = pc_q;
    link_addr = pc4_q;
    instr     = ir_q;
    opcode    = ir_q[31:26];
    rs        = ir_q[25:21];
    rt        = ir_q[20:16];
    rd        = ir_q[15:11];
    funct     = ir_q[5:0];
    imm16     = ir_q[15:0];
    retired   = retired_q;
    addr_err  = addr_err_q;
  end

endmodule

// File: tb/tb_pc_ir_unit.sv
// Self-checking bench for pc_ir_unit: directed scenarios followed by random
// stimulus, all checked against a behavioural model of the PC/IR rules.
module tb_pc_ir_unit;

  logic        clk;
  logic        rst;
  logic        pcwr;
  logic        irwr;
  logic [1:0]  npc_sel;
  logic        zero;
  logic [31:0] rs_data;
  logic [31:0] imem_rdata;
  logic [31:0] imem_addr;
  logic [31:0] pc;
  logic [31:0] link_addr;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [15:0] imm16;
  logic [31:0] retired;
  logic        addr_err;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Model state
  logic [31:0] m_pc, m_pc4, m_ir, m_ret;
  logic        m_err;

  pc_ir_unit dut (
    .clk        (clk),
    .rst        (rst),
    .pcwr       (pcwr),
    .irwr       (irwr),
    .npc_sel    (npc_sel),
    .zero       (zero),
    .rs_data    (rs_data),
    .imem_rdata (imem_rdata),
    .imem_addr  (imem_addr),
    .pc         (pc),
    .link_addr  (link_addr),
    .instr      (instr),
    .opcode     (opcode),
    .funct      (funct),
    .rs         (rs),
    .rt         (rt),
    .rd         (rd),
    .imm16      (imm16),
    .retired    (retired),
    .addr_err   (addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural update of the model for one clock edge
  task automatic model_edge(input logic r, input logic pw, input logic iw,
                            input logic [1:0] sel, input logic z,
                            input logic [31:0] rsd, input logic [31:0] rdata);
    logic [31:0] npc;
    logic [31:0] off;
    if (!r) begin
      m_pc = 32'h3000; m_pc4 = 32'h3004; m_ir = 0; m_ret = 0; m_err = 0;
      return;
    end
    off = 32'($signed(m_ir[15:0])) * 32'd4;
    case (sel)
      2'd0: npc = m_pc + 32'd4;
      2'd1: npc = z ? m_pc4 + off : m_pc4;
      2'd2: npc = (m_pc4 & 32'hF000_0000) | ((m_ir & 32'h03FF_FFFF) * 32'd4);
      default: npc = rsd & ~32'd3;
    endcase
    if (iw) begin
      m_ir  = rdata;
      m_pc4 = m_pc + 32'd4;
      m_ret = m_ret + 32'd1;
    end
    if (pw) begin
      if (sel == 2'd3 && (rsd % 4) != 0) m_err = 1'b1;
      m_pc = npc;
    end
  endtask

  task automatic check_all();
    check_val("pc",        pc,             m_pc);
    check_val("imem_addr", imem_addr,      m_pc);
    check_val("link_addr", link_addr,      m_pc4);
    check_val("instr",     instr,          m_ir);
    check_val("opcode",    32'(opcode),    m_ir >> 26);
    check_val("rs",        32'(rs),        (m_ir >> 21) % 32);
    check_val("rt",        32'(rt),        (m_ir >> 16) % 32);
    check_val("rd",        32'(rd),        (m_ir >> 11) % 32);
    check_val("funct",     32'(funct),     m_ir % 64);
    check_val("imm16",     32'(imm16),     m_ir % 65536);
    check_val("retired",   retired,        m_ret);
    check_val("addr_err",  32'(addr_err),  32'(m_err));
  endtask

  // One clock: drive at negedge, update model at posedge, check just after
  task automatic cyc(input logic r, input logic pw, input logic iw,
                     input logic [1:0] sel, input logic z,
                     input logic [31:0] rsd, input logic [31:0] rdata);
    @(negedge clk);
    rst = r; pcwr = pw; irwr = iw; npc_sel = sel; zero = z;
    rs_data = rsd; imem_rdata = rdata;
    @(posedge clk);
    model_edge(r, pw, iw, sel, z, rsd, rdata);
    #1;
    check_all();
  endtask

  task automatic rand_cyc(input logic r, input logic pw, input logic iw);
    cyc(r, pw, iw, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
        $urandom, $urandom);
  endtask

  logic [31:0] h_pc, h_ir, h_ret;

  initial begin
    rst = 1'b1; pcwr = 1'b0; irwr = 1'b0; npc_sel = 2'b00; zero = 1'b0;
    rs_data = 0; imem_rdata = 0;
    m_pc = 0; m_pc4 = 0; m_ir = 0; m_ret = 0; m_err = 0;

    // Reset then fetch
    cyc(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    check_val("rst_pc", pc, 32'h0000_3000);
    check_val("rst_link", link_addr, 32'h0000_3004);
    cyc(1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 32'h0, 32'h1000_FFFF);
    check_val("fetch_pc", pc, 32'h0000_3004);
    check_val("fetch_instr", instr, 32'h1000_FFFF);
    check_val("fetch_opcode", 32'(opcode), 32'h04);
    check_val("fetch_retired", retired, 32'd1);

    // beq taken then not taken
    cyc(1'b1, 1'b1, 1'b0, 2'd1, 1'b1, 32'h0, 32'h0);
    check_val("beq_taken_pc", pc, 32'h0000_3000);
    cyc(1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 32'h0, 32'h0);
    check_val("beq_not_taken_pc", pc, 32'h0000_3004);

    // jal then misaligned jr
    cyc(1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 32'h0, 32'h0);
    cyc(1'b1, 1'b0, 1'b1, 2'd0, 1'b0, 32'h0, 32'h0C00_0C10);
    cyc(1'b1, 1'b1, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
    check_val("jal_pc", pc, 32'h0000_3040);
    check_val("jal_link", link_addr, 32'h0000_3004);
    cyc(1'b1, 1'b1, 1'b0, 2'd3, 1'b0, 32'h0000_3006, 32'h0);
    check_val("jr_pc", pc, 32'h0000_3004);
    check_val("jr_err", 32'(addr_err), 32'd1);

    // Hold for 5 cycles with random other inputs
    h_pc = pc; h_ir = instr; h_ret = retired;
    for (int i = 0; i < 5; i++) begin
      rand_cyc(1'b1, 1'b0, 1'b0);
      check_val("hold_pc", pc, h_pc);
      check_val("hold_instr", instr, h_ir);
      check_val("hold_retired", retired, h_ret);
      check_val("hold_err", 32'(addr_err), 32'd1);
    end

    // Several fetches, then reset with both enables asserted
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 32'h0, $urandom);
    cyc(1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 32'h0, 32'hDEAD_BEEF);
    check_val("midrst_pc", pc, 32'h0000_3000);
    check_val("midrst_instr", instr, 32'h0);
    check_val("midrst_retired", retired, 32'h0);
    check_val("midrst_err", 32'(addr_err), 32'h0);

    // PC wrap via jr to the top of the address space
    cyc(1'b1, 1'b1, 1'b0, 2'd3, 1'b0, 32'hFFFF_FFFC, 32'h0);
    check_val("wrap_pre_pc", pc, 32'hFFFF_FFFC);
    check_val("wrap_aligned_err", 32'(addr_err), 32'h0);
    cyc(1'b1, 1'b1, 1'b1, 2'd0, 1'b0, 32'h0, 32'h1234_5678);
    check_val("wrap_pc", pc, 32'h0000_0000);
    check_val("wrap_link", link_addr, 32'h0000_0000);

    // Random traffic with occasional reset
    for (int i = 0; i < 3000; i++) begin
      rand_cyc(1'($urandom_range(0, 49) != 0), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Retired counter must only ever step by one (mod 2^32), including past 0xFFFFFFFF
  logic [31:0] prev_ret;
  logic        prev_valid = 1'b0;
  always @(posedge clk) begin
    #2;
    if (prev_valid && rst && retired != prev_ret)
      assert (retired == prev_ret + 32'd1)
        else $error("retired stepped from 0x%08h to 0x%08h", prev_ret, retired);
    prev_ret   = retired;
    prev_valid = 1'b1;
  end

endmodule

// File: doc/pc_ir_unit.md
PC_IR_UNIT -- requirements
Module: pc_ir_unit

Interface
REQ-001 SHALL provide port: clk  input  1  single rising-edge clock for all state.
REQ-002 SHALL provide port: rst  input  1  synchronous, active-low reset, sampled on rising clk edge.
REQ-003 SHALL provide port: pcwr  input  1  PC write enable from controller.
REQ-004 SHALL provide port: irwr  input  1  IR write enable from controller.
REQ-005 SHALL provide port: npc_sel  input  2  next-PC select: 00 seq, 01 beq, 10 j/jal, 11 jr.
REQ-006 SHALL provide port: zero  input  1  ALU zero flag, used only when npc_sel=01.
REQ-007 SHALL provide port: rs_data  input  32  register rs value, jr target.
REQ-008 SHALL provide port: imem_rdata  input  32  instruction word at imem_addr, combinational memory.
REQ-009 SHALL provide port: imem_addr  output  32  byte address to instruction memory, equals pc.
REQ-010 SHALL provide port: pc  output  32  current PC register.
REQ-011 SHALL provide port: link_addr  output  32  pc4_q, return address for jal (write_30).
REQ-012 SHALL provide port: instr  output  32  IR register contents.
REQ-013 SHALL provide ports: opcode 6 (IR[31:26]), funct 6 (IR[5:0]), rs/rt/rd 5 each, imm16 16 (IR[15:0]), all outputs decoded from IR.
REQ-014 SHALL provide port: retired  output  32  count of IR loads since reset.
REQ-015 SHALL provide port: addr_err  output  1  sticky flag, misaligned jr target seen.

Function
REQ-016 SHALL hold registers pc, pc4_q, ir, retired, addr_err; no other state.
REQ-017 On irwr=1 at edge: ir <= imem_rdata (addressed by pre-edge pc); pc4_q <= pc + 4; retired <= retired + 1.
REQ-018 On pcwr=1 at edge: pc <= npc, npc chosen from pre-edge values per REQ-019..REQ-022.
REQ-019 npc_sel=00: npc = pc + 4 (32-bit wrap, 0xFFFFFFFC -> 0x00000000).
REQ-020 npc_sel=01: zero=1 -> npc = pc4_q + (sign_ext(imm16) << 2); zero=0 -> npc = pc4_q; arithmetic mod 2^32.
REQ-021 npc_sel=10: npc = {pc4_q[31:28], ir[25:0], 2'b00}.
REQ-022 npc_sel=11: npc = {rs_data[31:2], 2'b00}; if rs_data[1:0] != 0, addr_err <= 1 in same edge.
REQ-023 pcwr=1 and irwr=1 same edge: both updates occur; IR/pc4_q take pre-edge pc; npc_sel=01/10 use pre-edge pc4_q and ir.
REQ-024 pcwr=0: pc holds regardless of npc_sel/zero/rs_data; irwr=0: ir, pc4_q, retired hold.
REQ-025 retired SHALL wrap 0xFFFFFFFF -> 0x00000000 without flag.
REQ-026 addr_err SHALL remain 1 until reset once set; set only when pcwr=1 and npc_sel=11.
REQ-027 imem_addr, opcode, funct, rs, rt, rd, imm16, link_addr SHALL be combinational from registers, no extra latency.
REQ-028 Latency: PC and IR changes visible on outputs one cycle after the enabling edge.

Reset
REQ-029 rst=0 at edge: pc <= 0x00003000, pc4_q <= 0x00003004, ir <= 0x00000000, retired <= 0, addr_err <= 0.
REQ-030 Reset SHALL override pcwr/irwr in same edge; mid-instruction reset discards partial state.
REQ-031 All outputs valid from first edge with rst=0; no asynchronous path from rst.

Verification
REQ-032 Reset then fetch: rst=0 one edge, then irwr=pcwr=1, npc_sel=00, imem_rdata=0x1000FFFF -> pc=0x00003004, instr=0x1000FFFF, opcode=0x04, retired=1.
REQ-033 Taken beq: after REQ-032, pcwr=1, npc_sel=01, zero=1 -> pc=0x00003000 (0x3004 + 0xFFFFFFFC); zero=0 case -> pc=0x00003004.
REQ-034 jal/jr: ir=0x0C000C10 loaded at pc=0x3000, pcwr npc_sel=10 -> pc=0x00003040, link_addr=0x00003004; then npc_sel=11, rs_data=0x00003006 -> pc=0x00003004, addr_err=1.
REQ-035 Hold: pcwr=irwr=0 for 5 cycles with random npc_sel/zero/rs_data/imem_rdata -> pc, instr, retired unchanged.
REQ-036 Mid-operation reset: after several fetches with addr_err=1, assert rst=0 together with pcwr=irwr=1 -> pc=0x00003000, instr=0, retired=0, addr_err=0.
REQ-037 Wrap: force pc=0xFFFFFFFC via jr, then npc_sel=00 pcwr -> pc=0x00000000; retired preloaded to 0xFFFFFFFF via 2^32 loads not required, bench checks wrap by formal/assertion.
